// File: rtl/result_collector.sv
// result_collector: three per-channel result FIFOs merged round-robin onto one backpressured memory write port.
module result_collector #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_we_0,
  input  logic              in_we_1,
  input  logic              in_we_2,
  input  logic [ADDR_W-1:0] in_addr_0,
  input  logic [ADDR_W-1:0] in_addr_1,
  input  logic [ADDR_W-1:0] in_addr_2,
  input  logic [DATA_W-1:0] in_y_0,
  input  logic [DATA_W-1:0] in_y_1,
  input  logic [DATA_W-1:0] in_y_2,
  output logic              mem_we,
  output logic [1:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ready,
  output logic [2:0]        overflow,
  output logic              busy,
  output logic [17:0]       wr_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int W = ADDR_W + DATA_W;
  typedef enum logic {IDLE, VALID} state_t;
  state_t state, state_n;
  logic [2:0] we, ne, full, pop, push;
  logic [W-1:0] word [3];
  logic [W-1:0] fifo [3][FIFO_DEPTH];
  logic [AW:0] wp [3];
  logic [AW:0] rp [3];
  logic [1:0] last, c1, c2, grant;
  logic load;
  function automatic logic [1:0] nxt(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction
  assign we = {in_we_2, in_we_1, in_we_0};
  assign word[0] = {in_addr_0, in_y_0};
  assign word[1] = {in_addr_1, in_y_1};
  assign word[2] = {in_addr_2, in_y_2};
  // Arbitration sees pre-push FIFO state; a full FIFO popped this edge still accepts a push.
  always_comb begin
    c1 = nxt(last);
    c2 = nxt(c1);
    for (int k = 0; k < 3; k++) begin
      ne[k] = wp[k] != rp[k];
      full[k] = (wp[k] ^ rp[k]) == {1'b1, {AW{1'b0}}};
    end
    grant = ne[c1] ? c1 : ne[c2] ? c2 : last;
    load = (state == IDLE || mem_ready) && |ne;
    for (int k = 0; k < 3; k++) begin
      pop[k] = load && grant == 2'(k);
      push[k] = we[k] && (!full[k] || pop[k]);
    end
  end
  always_comb state_n = load ? VALID : (state == VALID && mem_ready) ? IDLE : state;
  always_comb begin
    mem_we = state == VALID;
    busy = |ne || mem_we;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    for (int k = 0; k < 3; k++)
      if (push[k]) fifo[k][wp[k][AW-1:0]] <= word[k];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        wp[k] <= '0;
        rp[k] <= '0;
      end
      last <= 2'd2;
      mem_sel <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      overflow <= '0;
      wr_count <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (push[k]) wp[k] <= wp[k] + (AW+1)'(1);
        if (pop[k]) rp[k] <= rp[k] + (AW+1)'(1);
        overflow[k] <= overflow[k] | (we[k] & full[k] & ~pop[k]);
      end
      if (load) begin
        {mem_addr, mem_data} <= fifo[grant][rp[grant][AW-1:0]];
        mem_sel <= grant;
        last <= grant;
      end
      if (mem_we && mem_ready) wr_count <= wr_count + 18'd1;
    end
  end
endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: vector table, directed corner sequences and random traffic against a queue-based reference model.
module tb_result_collector;
  localparam int DEPTH = 4;
  logic clk_tb = 0;
  logic rst = 0;
  always #5 clk_tb = ~clk_tb;
  logic in_we_0, in_we_1, in_we_2, mem_ready;
  logic [15:0] in_addr_0, in_addr_1, in_addr_2, mem_addr;
  logic [7:0] in_y_0, in_y_1, in_y_2, mem_data;
  logic mem_we, busy;
  logic [1:0] mem_sel;
  logic [2:0] overflow;
  logic [17:0] wr_count;
  int n_chk = 0;
  int n_fail = 0;

  result_collector dut (
    .clk(clk_tb), .rst(rst),
    .in_we_0(in_we_0), .in_we_1(in_we_1), .in_we_2(in_we_2),
    .in_addr_0(in_addr_0), .in_addr_1(in_addr_1), .in_addr_2(in_addr_2),
    .in_y_0(in_y_0), .in_y_1(in_y_1), .in_y_2(in_y_2),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready), .overflow(overflow), .busy(busy), .wr_count(wr_count)
  );

  // Reference model: one queue per channel plus the presented word.
  logic [23:0] q[3][$];
  logic m_valid;
  logic [1:0] m_sel;
  logic [15:0] m_addr;
  logic [7:0] m_data;
  int m_last;
  logic [2:0] m_ovf;
  logic [17:0] m_cnt;
  always @(posedge clk_tb or posedge rst) begin : model
    int take;
    logic [2:0] w_en;
    logic [23:0] w[3];
    w_en = {in_we_2, in_we_1, in_we_0};
    w[0] = {in_addr_0, in_y_0};
    w[1] = {in_addr_1, in_y_1};
    w[2] = {in_addr_2, in_y_2};
    if (rst) begin
      for (int k = 0; k < 3; k++) q[k].delete();
      m_valid = 0; m_sel = 0; m_addr = 0; m_data = 0; m_last = 2; m_ovf = 0; m_cnt = 0;
    end else begin
      take = -1;
      if (m_valid && mem_ready) m_cnt++;
      if (!m_valid || mem_ready) begin
        for (int i = 1; i <= 3; i++)
          if (take < 0 && q[(m_last + i) % 3].size() > 0) take = (m_last + i) % 3;
        if (take >= 0) begin
          {m_addr, m_data} = q[take].pop_front();
          m_sel = 2'(take);
          m_last = take;
          m_valid = 1;
        end else m_valid = 0;
      end
      for (int k = 0; k < 3; k++)
        if (w_en[k]) begin
          if (q[k].size() < DEPTH) q[k].push_back(w[k]);
          else m_ovf[k] = 1;
        end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic mcheck();
    chk("model mem_we", 32'(mem_we), 32'(m_valid));
    if (m_valid) begin
      chk("model mem_sel", 32'(mem_sel), 32'(m_sel));
      chk("model mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("model mem_data", 32'(mem_data), 32'(m_data));
    end
    chk("model overflow", 32'(overflow), 32'(m_ovf));
    chk("model busy", 32'(busy), 32'(m_valid || q[0].size() > 0 || q[1].size() > 0 || q[2].size() > 0));
    chk("model wr_count", 32'(wr_count), 32'(m_cnt));
  endtask

  task automatic drive(input logic [2:0] we, input logic [15:0] a,
                       input logic [7:0] y0, input logic [7:0] y1, input logic [7:0] y2, input logic rdy);
    {in_we_2, in_we_1, in_we_0} = we;
    in_addr_0 = a; in_addr_1 = a; in_addr_2 = a;
    in_y_0 = y0; in_y_1 = y1; in_y_2 = y2;
    mem_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk_tb);
    #1;
    mcheck();
  endtask

  task automatic do_reset();
    rst = 1;
    drive(3'b000, 16'h0, 8'h0, 8'h0, 8'h0, 1'b1);
    @(posedge clk_tb);
    #1;
    rst = 0;
  endtask

  typedef struct {
    logic [2:0] we; logic [15:0] addr; logic [7:0] y0, y1, y2; logic rdy;
    logic e_we; logic [1:0] e_sel; logic [15:0] e_addr; logic [7:0] e_data; logic e_busy; logic [17:0] e_cnt;
  } vec_t;
  vec_t vt[8];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] got[$];
    logic [1:0] sels[$];
    int budget;
    vt[0] = '{3'b111, 16'h0020, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1, 18'd0};
    vt[1] = '{3'b000, 16'h0000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 2'd0, 16'h0020, 8'h11, 1'b1, 18'd0};
    vt[2] = '{3'b000, 16'h0000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 2'd1, 16'h0020, 8'h22, 1'b1, 18'd1};
    vt[3] = '{3'b000, 16'h0000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 2'd2, 16'h0020, 8'h33, 1'b1, 18'd2};
    vt[4] = '{3'b000, 16'h0000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b0, 18'd3};
    vt[5] = '{3'b010, 16'h0010, 8'h00, 8'h5A, 8'h00, 1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1, 18'd3};
    vt[6] = '{3'b000, 16'h0000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 2'd1, 16'h0010, 8'h5A, 1'b1, 18'd3};
    vt[7] = '{3'b000, 16'h0000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b0, 18'd4};
    drive(3'b000, 16'h0, 8'h0, 8'h0, 8'h0, 1'b1);
    #3 rst = 1;
    #1;
    chk("reset mem_we", 32'(mem_we), 0);
    chk("reset outputs", 32'({mem_sel, mem_addr, mem_data}), 0);
    chk("reset overflow", 32'(overflow), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset wr_count", 32'(wr_count), 0);
    @(posedge clk_tb);
    #1 rst = 0;
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].we, vt[i].addr, vt[i].y0, vt[i].y1, vt[i].y2, vt[i].rdy);
      tick();
      chk($sformatf("vec%0d mem_we", i), 32'(mem_we), 32'(vt[i].e_we));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vt[i].e_busy));
      chk($sformatf("vec%0d wr_count", i), 32'(wr_count), 32'(vt[i].e_cnt));
      if (vt[i].e_we) begin
        chk($sformatf("vec%0d mem_sel", i), 32'(mem_sel), 32'(vt[i].e_sel));
        chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(vt[i].e_addr));
        chk($sformatf("vec%0d mem_data", i), 32'(mem_data), 32'(vt[i].e_data));
      end
    end
    // Backpressure holds the presented word stable.
    do_reset();
    drive(3'b001, 16'h0033, 8'h77, 8'h0, 8'h0, 1'b0);
    tick();
    drive(3'b000, 16'h0, 8'h0, 8'h0, 8'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("stall mem_we", 32'(mem_we), 1);
      chk("stall word", 32'({mem_sel, mem_addr, mem_data}), 32'({2'd0, 16'h0033, 8'h77}));
      chk("stall wr_count", 32'(wr_count), 0);
    end
    mem_ready = 1;
    tick();
    chk("release wr_count", 32'(wr_count), 1);
    chk("release mem_we", 32'(mem_we), 0);
    tick();
    chk("release once", 32'(wr_count), 1);
    // Overflow on channel 2 while the output stage is stalled on channel 0.
    do_reset();
    drive(3'b001, 16'h0001, 8'hAA, 8'h0, 8'h0, 1'b0);
    tick();
    for (int i = 1; i <= 5; i++) begin
      drive(3'b100, 16'h0002, 8'h0, 8'h0, 8'(i), 1'b0);
      tick();
    end
    chk("overflow flag", 32'(overflow), 32'(3'b100));
    drive(3'b000, 16'h0, 8'h0, 8'h0, 8'h0, 1'b1);
    budget = 20;
    while (busy && budget > 0) begin
      if (mem_we) got.push_back(mem_data);
      tick();
      budget--;
    end
    chk("overflow drain bound", 32'(budget > 0), 1);
    chk("overflow count", 32'(got.size()), 5);
    if (got.size() == 5) begin
      chk("overflow first", 32'(got[0]), 32'h AA);
      for (int i = 1; i < 5; i++) chk($sformatf("overflow data%0d", i), 32'(got[i]), 32'(i));
    end
    chk("overflow sticky", 32'(overflow), 32'(3'b100));
    // Fairness between two continuously writing channels.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(3'b101, 16'h0040, 8'(8'h40 + i), 8'h0, 8'(8'h80 + i), 1'b1);
      tick();
      if (mem_we) sels.push_back(mem_sel);
    end
    chk("fair count", 32'(sels.size() >= 6), 1);
    for (int i = 0; i < 6 && i < sels.size(); i++)
      chk($sformatf("fair sel%0d", i), 32'(sels[i]), (i % 2) ? 2 : 0);
    // Asynchronous reset between edges mid-burst.
    do_reset();
    drive(3'b111, 16'h0099, 8'h1, 8'h2, 8'h3, 1'b0);
    tick();
    tick();
    #2 rst = 1;
    #1;
    chk("async mem_we", 32'(mem_we), 0);
    chk("async outputs", 32'({mem_sel, mem_addr, mem_data}), 0);
    chk("async busy", 32'(busy), 0);
    chk("async overflow", 32'(overflow), 0);
    chk("async wr_count", 32'(wr_count), 0);
    tick();
    chk("reset ignores in_we", 32'(busy), 0);
    #2 rst = 0;
    drive(3'b000, 16'h0, 8'h0, 8'h0, 8'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post reset mem_we", 32'(mem_we), 0);
      chk("post reset wr_count", 32'(wr_count), 0);
    end
    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      drive(3'($urandom_range(0, 7) & $urandom_range(0, 7)), 16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            ($urandom % 4) != 0);
      in_addr_1 = 16'($urandom);
      in_addr_2 = 16'($urandom);
      tick();
    end
    drive(3'b000, 16'h0, 8'h0, 8'h0, 8'h0, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    chk("random drained", 32'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
